alert_hub_fsm: RTL
==================

ALERT_HUB_FSM -- requirements
Module: alert_hub_fsm

Interface
REQ-001 Parameter N_CH, default 4, number of independent sensor channels (1..16).
REQ-002 Parameter DEBOUNCE, default 2, consecutive sampled anomaly codes needed to enter ALERT (1..15).
REQ-003 Parameter TIMEOUT, default 16, unacknowledged ALERT cycles before ESCALATED (2..255).
REQ-004 Parameter DUTY, default 4, NORMAL-state sensor wake period in cycles (1..16; 1 = always on).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 ai_signal  in  2*N_CH  per-channel AI code, channel i at [2i+1:2i]: 00 normal, 01 suspect, 10 anomaly, 11 treated as normal.
REQ-008 ack  in  N_CH  per-channel alert acknowledge, level-sampled each cycle.
REQ-009 state  out  2*N_CH  per-channel registered state: 00 NORMAL, 01 WATCH, 10 ALERT, 11 ESCALATED.
REQ-010 sensor_enable  out  N_CH  per-channel sensor power enable.
REQ-011 alert_flag  out  1  high while any channel is in ALERT or ESCALATED.
REQ-012 escalate  out  1  high while any channel is in ESCALATED.
REQ-013 uart_valid  out  1  state-change event available.
REQ-014 uart_ready  in  1  downstream UART accepts event when high with uart_valid.
REQ-015 uart_ch  out  max(1,clog2(N_CH))  channel index of presented event.
REQ-016 uart_data  out  8  ASCII of that channel's current state: "0", "1", "A", "E".

Function
REQ-017 ai_signal[i] evaluated only in cycles where sensor_enable[i]=1 ("sample cycles").
REQ-018 sensor_enable[i]=1 in WATCH/ALERT/ESCALATED; in NORMAL =1 only when shared duty counter (0..DUTY-1, free-running, wraps) is 0.
REQ-019 Per-channel anomaly counter: +1 on sampled 10, held on sampled 01, cleared on sampled 00/11; saturates at DEBOUNCE.
REQ-020 NORMAL: sampled 10 with counter+1=DEBOUNCE -> ALERT; otherwise sampled 01 or 10 -> WATCH; else stay.
REQ-021 WATCH: sampled 10 with counter+1=DEBOUNCE -> ALERT; sampled 00/11 -> NORMAL; else stay.
REQ-022 ALERT: ack[i]=1 -> NORMAL; else timeout counter +1; reaching TIMEOUT -> ESCALATED.
REQ-023 ESCALATED: ack[i]=1 -> NORMAL; else stay.
REQ-024 Entering NORMAL clears anomaly and timeout counters; entering ALERT clears timeout counter; ai_signal ignored in ALERT/ESCALATED.
REQ-025 ack in NORMAL/WATCH has no effect; ack and timeout expiry in the same cycle -> ack wins (NORMAL).
REQ-026 State transitions take effect at the clock edge after the deciding sample (1-cycle latency); alert_flag/escalate are combinational from registered state.
REQ-027 Any change of state[i] sets pending bit pend[i] at the same edge.
REQ-028 uart_valid = OR of pend; uart_ch = lowest-index pending channel; uart_data from that channel's current state (latest state wins if changed twice while pending).
REQ-029 uart_valid&uart_ready clears pend[uart_ch]; if that channel changes state in the same cycle, pend stays set.
REQ-030 uart_ch/uart_data stable while uart_valid high and uart_ready low unless a lower-index channel becomes pending.

Reset
REQ-031 Reset asserted: all channels NORMAL, all counters 0, duty counter 0, pend 0; therefore state=0, sensor_enable=all 1, alert_flag=0, escalate=0, uart_valid=0, uart_ch=0, uart_data="0".
REQ-032 Reset asserted mid-ALERT/ESCALATED or with pending events discards them immediately; no event generated for the reset transition.

Structure
REQ-033 Package alert_pkg holds state encodings, AI code constants and ASCII constants.
REQ-034 Sub-module alert_ch_fsm implements one channel (REQ-017..025), instantiated N_CH times by generate; duty counter, pending/arbiter logic in top.

Verification (N_CH=4, DEBOUNCE=2, TIMEOUT=16, DUTY=4)
REQ-035 Reset, all ai_signal=00 for 12 cycles -> state=0, sensor_enable[i] high cycles 0,4,8 only, uart_valid=0.
REQ-036 ch1 sampled 10, 10 -> WATCH then ALERT; alert_flag=1; events ch1 "1" then "A" with uart_ready=1.
REQ-037 ch2 in ALERT, no ack 16 cycles -> ESCALATED, escalate=1, event "E"; ack[2] pulse -> NORMAL, event "0".
REQ-038 ch0 ALERT, ack[0]=1 on the timeout cycle -> NORMAL, never ESCALATED.
REQ-039 ch3 and ch0 change same cycle, uart_ready=0 for 5 cycles -> uart_ch=0 held; then ready=1 -> ch0 then ch3 delivered.
REQ-040 reset driven low while ch1 ESCALATED with pend set -> outputs return to REQ-031 values asynchronously, uart_valid=0.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared encodings for the alert hub: channel states, AI codes, ASCII event bytes.
package alert_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'b00,
        ST_WATCH     = 2'b01,
        ST_ALERT     = 2'b10,
        ST_ESCALATED = 2'b11
    } ch_state_e;

    localparam logic [1:0] AI_NORMAL  = 2'b00;
    localparam logic [1:0] AI_SUSPECT = 2'b01;
    localparam logic [1:0] AI_ANOMALY = 2'b10;
    localparam logic [1:0] AI_INVALID = 2'b11;

    localparam logic [7:0] ASC_NORMAL    = 8'h30;  // "0"
    localparam logic [7:0] ASC_WATCH     = 8'h31;  // "1"
    localparam logic [7:0] ASC_ALERT     = 8'h41;  // "A"
    localparam logic [7:0] ASC_ESCALATED = 8'h45;  // "E"

    // ASCII character reported on the UART for a given channel state.
    function automatic logic [7:0] state_ascii(input ch_state_e s);
        logic [7:0] c;
        case (s)
            ST_NORMAL:    c = ASC_NORMAL;
            ST_WATCH:     c = ASC_WATCH;
            ST_ALERT:     c = ASC_ALERT;
            ST_ESCALATED: c = ASC_ESCALATED;
            default:      c = ASC_NORMAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alert_ch_fsm.sv
// One sensor channel: debounced anomaly detection, alert timeout and acknowledge.
module alert_ch_fsm
    import alert_pkg::*;
#(
    parameter int DEBOUNCE = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [1:0] ai_code,
    input  logic       ack,
    output ch_state_e  state_o,
    output logic       chg_o
);

    localparam logic [3:0] DEB_C = 4'(DEBOUNCE);
    localparam logic [7:0] TMO_C = 8'(TIMEOUT);

    ch_state_e  state_q, state_d;
    logic [3:0] anom_q, anom_d;
    logic [7:0] tmo_q, tmo_d;
    logic [3:0] anom_inc_s;
    logic       hit_s;

    // Next-state, anomaly counter and timeout counter for this channel.
    always_comb begin
        state_d = state_q;
        anom_d  = anom_q;
        tmo_d   = tmo_q;
        // The anomaly that completes the debounce run is the one that makes
        // the count reach DEBOUNCE; the counter itself saturates there.
        hit_s   = ((anom_q + 4'd1) == DEB_C);
        if (anom_q >= DEB_C) begin
            anom_inc_s = DEB_C;
        end else begin
            anom_inc_s = anom_q + 4'd1;
        end

        case (state_q)
            ST_NORMAL, ST_WATCH: begin
                // ack has no meaning here; only sampled codes move the state.
                if (sample_en) begin
                    case (ai_code)
                        AI_ANOMALY: begin
                            anom_d = anom_inc_s;
                            if (hit_s) begin
                                state_d = ST_ALERT;
                                tmo_d   = 8'd0;
                            end else begin
                                state_d = ST_WATCH;
                            end
                        end
                        AI_SUSPECT: begin
                            state_d = ST_WATCH;
                        end
                        default: begin
                            // 00 and the reserved 11 both read as normal.
                            state_d = ST_NORMAL;
                            anom_d  = 4'd0;
                            tmo_d   = 8'd0;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_ALERT: begin
                // Acknowledge beats a timeout expiring in the same cycle.
                if (ack) begin
                    state_d = ST_NORMAL;
                    anom_d  = 4'd0;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if ((tmo_q + 8'd1) == TMO_C) begin
                        state_d = ST_ESCALATED;
                    end else begin
                        state_d = ST_ALERT;
                    end
                end
            end
            ST_ESCALATED: begin
                if (ack) begin
                    state_d = ST_NORMAL;
                    anom_d  = 4'd0;
                    tmo_d   = 8'd0;
                end else begin
                    state_d = ST_ESCALATED;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                anom_d  = 4'd0;
                tmo_d   = 8'd0;
            end
        endcase
    end

    // Channel state and counters, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            anom_q  <= 4'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            anom_q  <= anom_d;
            tmo_q   <= tmo_d;
        end
    end

    assign state_o = state_q;
    assign chg_o   = (state_d != state_q);

endmodule

// File: rtl/alert_hub_fsm.sv
// Multi-channel alert hub: duty-cycled sensor power, per-channel FSMs and a
// lowest-index-first UART event queue of state changes.
module alert_hub_fsm
    import alert_pkg::*;
#(
    parameter int  N_CH     = 4,
    parameter int  DEBOUNCE = 2,
    parameter int  TIMEOUT  = 16,
    parameter int  DUTY     = 4,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2*N_CH-1:0] ai_signal,
    input  logic [N_CH-1:0]   ack,
    output logic [2*N_CH-1:0] state,
    output logic [N_CH-1:0]   sensor_enable,
    output logic              alert_flag,
    output logic              escalate,
    output logic              uart_valid,
    input  logic              uart_ready,
    output logic [CH_W-1:0]   uart_ch,
    output logic [7:0]        uart_data
);

    localparam logic [3:0] DUTY_LAST = 4'(DUTY - 1);

    logic [3:0]      duty_q, duty_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] chg_s;
    ch_state_e       ch_st [N_CH];
    logic [CH_W-1:0] sel_s;
    logic            found_s;
    logic            take_s;

    // Free-running duty counter that wakes idle sensors once per period.
    always_comb begin
        if (duty_q >= DUTY_LAST) begin
            duty_d = 4'd0;
        end else begin
            duty_d = duty_q + 4'd1;
        end
    end

    // Duty counter and pending-event flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_q <= 4'd0;
            pend_q <= {N_CH{1'b0}};
        end else begin
            duty_q <= duty_d;
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        alert_ch_fsm #(
            .DEBOUNCE (DEBOUNCE),
            .TIMEOUT  (TIMEOUT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (reset),
            .sample_en (sensor_enable[g]),
            .ai_code   (ai_signal[2*g +: 2]),
            .ack       (ack[g]),
            .state_o   (ch_st[g]),
            .chg_o     (chg_s[g])
        );
    end

    // State bus, sensor power enables and the summary alarm flags.
    always_comb begin
        state         = {(2*N_CH){1'b0}};
        sensor_enable = {N_CH{1'b0}};
        alert_flag    = 1'b0;
        escalate      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            state[2*i +: 2]  = ch_st[i];
            sensor_enable[i] = (ch_st[i] != ST_NORMAL) || (duty_q == 4'd0);
            alert_flag       = alert_flag | (ch_st[i] == ST_ALERT) | (ch_st[i] == ST_ESCALATED);
            escalate         = escalate | (ch_st[i] == ST_ESCALATED);
        end
    end

    // Fixed-priority pick of the lowest pending channel and pending update.
    always_comb begin
        sel_s   = {CH_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (pend_q[i] && !found_s) begin
                sel_s   = CH_W'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        uart_valid = |pend_q;
        uart_ch    = sel_s;
        // Data tracks the channel's live state, so a second change while
        // still pending reports only the latest state.
        uart_data  = state_ascii(ch_st[sel_s]);
        take_s     = uart_valid & uart_ready;
        pend_d     = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            // A fresh change in the delivery cycle keeps the flag set.
            pend_d[i] = chg_s[i] | (pend_q[i] & ~(take_s & (sel_s == CH_W'(i))));
        end
    end

endmodule
